// File: rtl/intpol2_d4_out_wr.sv
// Output-side write controller for the degree-2 x4 interpolator: buffers accepted
// samples in a small skid FIFO and drains them as addressed write strobes.
module intpol2_d4_out_wr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   ilen,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  Full,
  output logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TOT_W = DATA_WIDTH + 3;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [TOT_W-1:0]      total, acc_cnt, wr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop, start_run;

  // Full check uses pre-pop occupancy; in_ready is decoded from registered state.
  assign in_ready  = (state == RUN) && (count < CNT_W'(DEPTH)) && (acc_cnt < total);
  assign push      = in_valid && in_ready;
  assign pop       = (count != '0) && !Full;
  assign start_run = (state == IDLE) && start && (ilen != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (ilen == '0) ? DONE : RUN;
      RUN:     if (push && ((acc_cnt + TOT_W'(1)) == total)) state_nxt = DRAIN;
      DRAIN:   if ((wr_cnt == total) && (count == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (clear) begin
      total   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (state == IDLE && start) begin
      total   <= TOT_W'(ilen) << 2;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push) acc_cnt <= acc_cnt + TOT_W'(1);
      if (pop)  wr_cnt  <= wr_cnt + TOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Write address is the running write count, wrapping at 2^ADDR_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Write_Enable <= 1'b0;
      wr_data      <= '0;
      wr_addr      <= '0;
    end else if (clear) begin
      Write_Enable <= 1'b0;
      wr_data      <= '0;
      wr_addr      <= '0;
    end else begin
      Write_Enable <= pop;
      if (pop) begin
        wr_data <= mem[rd_ptr];
        wr_addr <= ADDR_WIDTH'(wr_cnt);
      end else if (start_run) begin
        wr_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_intpol2_d4_out_wr.sv
// Scoreboard bench for intpol2_d4_out_wr: a 16-bit-address and a 3-bit-address
// instance share stimulus; a monitor checks every write strobe against the queue.
module tb_intpol2_d4_out_wr;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned SAW = 3;

  logic          clk = 1'b0;
  logic          rst, clear, start, in_valid, Full;
  logic [DW:0]   ilen;
  logic [DW-1:0] in_data;
  logic          in_ready, we, busy, done;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          in_ready_s, we_s, busy_s, done_s;
  logic [DW-1:0] wr_data_s;
  logic [SAW-1:0] wr_addr_s;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  int            applied = 0, miscompares = 0;
  int            cyc = 0, total_writes = 0, last_we_cyc = -10, run_base = 0;
  int            accepted = 0, done_cnt = 0, done_base = 0, n = 0, w = 0;
  logic [AW-1:0] exp_addr;
  bit            abort;
  logic          full_d;

  intpol2_d4_out_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .ilen(ilen),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .Full(Full),
    .Write_Enable(we), .wr_data(wr_data), .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  intpol2_d4_out_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(SAW), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .ilen(ilen),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s), .Full(Full),
    .Write_Enable(we_s), .wr_data(wr_data_s), .wr_addr(wr_addr_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
  end

  // Monitor: every write strobe pops one expected entry.
  initial begin
    exp_t e;
    full_d = 1'b0;
    forever begin
      @(negedge clk);
      if (full_d && !rst) chk("no_write_after_full", 64'(we), 64'(0));
      if (we) begin
        total_writes++;
        last_we_cyc = cyc;
        if (q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("narrow_we", 64'(we_s), 64'(1));
          chk("narrow_wr_data", 64'(wr_data_s), 64'(e.data));
          chk("narrow_wr_addr_wrap", 64'(wr_addr_s), 64'(e.addr[SAW-1:0]));
        end
      end
      full_d = Full;
    end
  end

  task automatic do_start(input logic [DW:0] len);
    ilen     = len;
    start    = 1'b1;
    exp_addr = '0;
    run_base = total_writes;
    accepted = 0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input int cnt, input logic [DW-1:0] base);
    int i = 0;
    int guard = 0;
    bit acc;
    in_valid = 1'b1;
    in_data  = base;
    while (i < cnt && !abort) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc && !abort) begin
        q.push_back('{data: in_data, addr: exp_addr});
        exp_addr++;
        i++;
        accepted++;
        in_data = base + DW'(i);
      end
      guard++;
      if (guard > 300) begin
        applied++;
        miscompares++;
        $display("FAIL send_timeout: got %0d accepted, expected %0d", i, cnt);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_writes, output int waited);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      if (done) seen = 1;
      else k++;
    end
    waited = k;
    if (!seen) begin
      applied++;
      miscompares++;
      $display("FAIL %s_done_timeout: got no done, expected done within 200 cycles", name);
    end else begin
      chk({name, "_write_count"}, 64'(total_writes - run_base), 64'(exp_writes));
      if (exp_writes > 0) chk({name, "_done_after_last_write"}, 64'(cyc), 64'(last_we_cyc + 1));
      chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
      chk({name, "_queue_drained"}, 64'(q.size()), 64'(0));
      @(negedge clk);
      chk({name, "_done_single_pulse"}, 64'(done), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; ilen = '0; in_valid = 1'b0;
    in_data = '0; Full = 1'b0; abort = 1'b0; exp_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;

    // Basic run: 12 writes, narrow instance wraps addresses 0..7,0..3
    do_start(3);
    @(negedge clk);
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(12, 32'h0000_1000);
    wait_done("basic", 12, w);
    @(posedge clk); #1;

    // Back-pressure: Full high for 6 cycles right after start
    do_start(2);
    Full = 1'b1;
    fork
      send(8, 32'h0000_2000);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts_before_stall", 64'(accepted), 64'(4));
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_still_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 Full = 1'b0;
      end
    join
    wait_done("bp", 8, w);
    @(posedge clk); #1;

    // Zero length
    do_start(0);
    wait_done("zero", 0, w);
    chk("zero_done_latency", 64'(w), 64'(0));
    @(posedge clk); #1;

    // Mid-run clear after 5 writes
    do_start(4);
    fork
      send(16, 32'h0000_3000);
      begin
        n = 0;
        while (total_writes - run_base < 5 && n < 100) begin
          @(negedge clk);
          #1;
          n++;
        end
        if (n >= 100) begin
          applied++;
          miscompares++;
          $display("FAIL clear_wait_timeout: got %0d writes, expected 5", total_writes - run_base);
        end
        clear = 1'b1;
        abort = 1'b1;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        chk("clr_in_ready", 64'(in_ready), 64'(0));
        chk("clr_we", 64'(we), 64'(0));
        chk("clr_wr_data", 64'(wr_data), 64'(0));
        chk("clr_wr_addr", 64'(wr_addr), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_done", 64'(done), 64'(0));
        chk("clr_narrow_busy", 64'(busy_s), 64'(0));
        clear = 1'b0;
        q.delete();
      end
    join
    repeat (3) @(negedge clk);
    chk("clr_no_done_pulse", 64'(done_cnt - done_base), 64'(0));
    chk("clr_write_count", 64'(total_writes - run_base), 64'(5));
    chk("clr_narrow_done", 64'(done_s), 64'(0));
    @(posedge clk); #1;
    abort = 1'b0;
    do_start(1);
    send(4, 32'h0000_4000);
    wait_done("restart", 4, w);
    @(posedge clk); #1;

    // start while busy is ignored
    do_start(2);
    ilen  = 5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_start_busy", 64'(busy), 64'(1));
    send(8, 32'h0000_5000);
    @(negedge clk);
    chk("busy_start_ready_after_total", 64'(in_ready), 64'(0));
    wait_done("busy_start", 8, w);
    @(posedge clk); #1;

    // Async reset between edges
    do_start(1);
    fork
      send(4, 32'h0000_6000);
      begin
        n = 0;
        while (!we && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (n >= 50) begin
          applied++;
          miscompares++;
          $display("FAIL arst_wait_timeout: got no write strobe, expected one within 50 cycles");
        end
        #1 rst = 1'b1;
        abort = 1'b1;
        #1;
        chk("arst_we", 64'(we), 64'(0));
        chk("arst_narrow_we", 64'(we_s), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_wr_addr", 64'(wr_addr), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(0));
        chk("arst_narrow_in_ready", 64'(in_ready_s), 64'(0));
      end
    join
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/intpol2_d4_out_wr.md
# intpol2_D4_out_wr

Output-side write controller for the degree-2, ×4 interpolator. It accepts interpolated samples from the interpolator datapath over a valid/ready handshake and buffers them in a small internal FIFO. It drains them as write strobes with an incrementing address into the output FIFO/memory, and signals completion once exactly `ilen*4` samples have been written. It is the consumer end of the sample stream whose producer end is the interpolator's next-state/load logic.

## Interface
- `DATA_WIDTH`, 32, sample width; `ilen` is `DATA_WIDTH+1` bits, matching the interpolator core.
- `ADDR_WIDTH`, 16, output write-address width.
- `DEPTH`, 4, internal skid FIFO depth (power of two, ≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear: same effect as `rst`, applied at the next edge.
- `start`  in  1  one-cycle pulse; latches `ilen`; ignored unless in IDLE.
- `ilen`  in  DATA_WIDTH+1  input sample count; required outputs = `ilen*4`.
- `in_valid`  in  1  datapath sample valid.
- `in_data`  in  DATA_WIDTH  interpolated sample.
- `in_ready`  out  1  controller can accept a sample this cycle.
- `Full`  in  1  output FIFO/memory full; no write is issued while high.
- `Write_Enable`  out  1  registered write strobe.
- `wr_data`  out  DATA_WIDTH  registered write data.
- `wr_addr`  out  ADDR_WIDTH  registered write address.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Internal registers:
  - `total` (DATA_WIDTH+3 bits) = `ilen << 2`, latched on `start`.
  - `acc_cnt`: accepted samples.
  - `wr_cnt`: written samples.
  - FIFO: read/write pointers plus an occupancy count of 0..DEPTH.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start` with `ilen != 0`, go to RUN and zero `acc_cnt`, `wr_cnt` and `wr_addr`. On `start` with `ilen == 0`, go straight to DONE.
  - RUN: on accept, `acc_cnt` reaches `total`, go to DRAIN.
  - DRAIN: when `wr_cnt == total` and the FIFO is empty, go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Accept rule:
  - `in_ready = (state == RUN) && (occupancy < DEPTH) && (acc_cnt < total)`. It is combinational from registered state.
  - A sample is accepted when `in_valid && in_ready`, and is pushed into the FIFO.
- Write rule:
  - Each cycle, if FIFO non-empty and `Full == 0` (sampled this cycle), pop the head.
  - On the next edge, register `Write_Enable = 1`, `wr_data = head`, `wr_addr = current address`; then increment the address and `wr_cnt`.
  - Otherwise `Write_Enable = 0`; `wr_data` and `wr_addr` hold their values.
- Simultaneous push and pop are allowed; occupancy is unchanged.
- The full check uses pre-pop occupancy, so there is no push when occupancy == DEPTH, even if a pop occurs in the same cycle.
- `wr_addr` wraps modulo 2^ADDR_WIDTH with no error.
- `clear` or `rst` mid-operation: FIFO emptied, counters zeroed, state returns to IDLE, no `done` pulse. Samples in flight are discarded.
- `start` while busy is ignored; `total` is not re-latched.

## Timing
- Reset and clear values: `in_ready` 0, `Write_Enable` 0, `wr_data` 0, `wr_addr` 0, `busy` 0, `done` 0, state IDLE, FIFO empty.
- `start` at edge t puts the block in RUN and raises `busy` after t. `in_ready` is high in the cycle following t.
- Minimum latency: a sample accepted at edge t, with the FIFO empty and `Full` low, appears as `Write_Enable` after edge t+1.
- Sustained throughput: 1 sample/cycle while `Full` stays low.
- `Full` asserted in cycle c means no `Write_Enable` after edge c+1. Back-pressure reaches `in_ready` once occupancy hits DEPTH.
- Timing of `done`:
  - `done` is high in the cycle after the last write strobe is registered, concurrent with state DONE.
  - `busy` falls in the same cycle `done` rises.
- `ilen == 0`: `done` is high in the cycle after the `start` edge; no writes are issued.

## Test plan
- Basic run: `ilen`=3, `in_valid` held high, `Full`=0.
  - Exactly 12 writes, `wr_addr` 0..11, `wr_data` equal to the inputs in order.
  - `done` is a single pulse one cycle after the write to address 11.
- Back-pressure: `ilen`=2, `Full` high for 6 cycles mid-stream.
  - `in_ready` drops after 4 more accepts.
  - No data loss or duplication; 8 writes in order.
- Zero length: `start` with `ilen`=0.
  - `done` pulses one cycle later; `Write_Enable` never asserts; `busy` stays 0.
- Address wrap: `ADDR_WIDTH`=3, `ilen`=3.
  - Addresses are 0..7 then 0..3; `done` pulses after 12 writes.
- Mid-run abort: assert `clear` after 5 writes of an `ilen`=4 run.
  - Next cycle: all outputs at reset values, no `done`.
  - A fresh `start` restarts at `wr_addr` 0.
- Busy start and async reset:
  - A `start` pulse during RUN changes nothing; the count stays at the original `total`.
  - `rst` asserted between edges clears `Write_Enable` immediately.
